// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Circular store buffer between the LSU address stage and the D-cache.
// Stores enter speculatively. A commit makes the oldest speculative entry
// committed. Committed entries drain to the D-cache in order through a
// req/gnt handshake. A flush discards every speculative entry and leaves
// committed entries and the drain untouched.
//
// Parameters:
//   DEPTH  number of entries; power of two, 2 or more
//   PLEN   physical address width
//
// Ports:
//   clk_i                sole clock, rising edge
//   rst_i                synchronous, active-high reset
//   flush_i              discard all speculative entries
//   valid_i / ready_o    store request / buffer can accept a store
//   paddr_i, data_i,
//   be_i, size_i         store fields (size: 00 byte .. 11 double)
//   commit_i             commit the oldest speculative entry
//   commit_ready_o       a speculative entry exists
//   no_st_pending_o      buffer completely empty
//   mem_req_o/mem_gnt_i  drain handshake to the D-cache
//   mem_addr_o, mem_data_o,
//   mem_be_o, mem_size_o fields of the oldest committed entry
//   page_offset_i        load page offset for the hazard check
//   page_offset_match_o  a valid entry matches page_offset_i[11:3]
//
// Compile-time option:
//   SB_PAGE_OFFSET_CHECK_EN  enables the page-offset comparator. When it is
//                            undefined, page_offset_match_o is tied to 0.
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PLEN  = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [PLEN-1:0] paddr_i,
    input  logic [63:0]     data_i,
    input  logic [7:0]      be_i,
    input  logic [1:0]      size_i,
    input  logic            commit_i,
    output logic            commit_ready_o,
    output logic            no_st_pending_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [PLEN-1:0] mem_addr_o,
    output logic [63:0]     mem_data_o,
    output logic [7:0]      mem_be_o,
    output logic [1:0]      mem_size_o,
    input  logic [11:0]     page_offset_i,
    output logic            page_offset_match_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Entry storage (not reset)
    logic [PLEN-1:0] addr_q [DEPTH];
    logic [63:0]     data_q [DEPTH];
    logic [7:0]      be_q   [DEPTH];
    logic [1:0]      size_q [DEPTH];

    // Pointers and occupancy counts
    logic [AW-1:0] drain_ptr;
    logic [AW-1:0] commit_ptr;
    logic [AW-1:0] write_ptr;
    logic [AW:0]   spec_cnt;
    logic [AW:0]   com_cnt;
    logic [AW:0]   total;

    logic write_en;
    logic commit_en;
    logic drain_en;

    assign total = spec_cnt + com_cnt;

    // All status outputs come from registered state only
    assign ready_o         = (total < FULL_CNT);
    assign commit_ready_o  = (spec_cnt != '0);
    assign mem_req_o       = (com_cnt != '0);
    assign no_st_pending_o = (total == '0);

    assign mem_addr_o = addr_q[drain_ptr];
    assign mem_data_o = data_q[drain_ptr];
    assign mem_be_o   = be_q[drain_ptr];
    assign mem_size_o = size_q[drain_ptr];

    // A store arriving with a flush is dropped
    assign write_en  = valid_i & ready_o & ~flush_i;
    assign commit_en = commit_i & commit_ready_o;
    assign drain_en  = mem_req_o & mem_gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_ptr  <= '0;
            commit_ptr <= '0;
            write_ptr  <= '0;
            spec_cnt   <= '0;
            com_cnt    <= '0;
        end else begin
            drain_ptr  <= drain_ptr + AW'(drain_en);
            commit_ptr <= commit_ptr + AW'(commit_en);
            com_cnt    <= com_cnt + (AW+1)'(commit_en) - (AW+1)'(drain_en);
            if (flush_i) begin
                // Same-cycle commit lands first; everything after it is discarded
                write_ptr <= commit_ptr + AW'(commit_en);
                spec_cnt  <= '0;
            end else begin
                write_ptr <= write_ptr + AW'(write_en);
                spec_cnt  <= spec_cnt + (AW+1)'(write_en) - (AW+1)'(commit_en);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_en && !rst_i) begin
            addr_q[write_ptr] <= paddr_i;
            data_q[write_ptr] <= data_i;
            be_q[write_ptr]   <= be_i;
            size_q[write_ptr] <= size_i;
        end
    end

`ifdef SB_PAGE_OFFSET_CHECK_EN
    logic [AW-1:0] rel_idx;
    logic          match;
    logic          unused_po_bits;

    assign unused_po_bits = ^page_offset_i[2:0];

    // An entry is valid when its distance from drain_ptr is below total
    always_comb begin
        match   = 1'b0;
        rel_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel_idx = AW'(i) - drain_ptr;
            if (({1'b0, rel_idx} < total) &&
                (addr_q[i][11:3] == page_offset_i[11:3])) begin
                match = 1'b1;
            end
        end
    end

    assign page_offset_match_o = match;
`else
    logic unused_po_bits;

    assign unused_po_bits      = ^page_offset_i;
    assign page_offset_match_o = 1'b0;
`endif

endmodule
